// File: rtl/ysyx_2022040010_uncache_ctrl.sv
// Uncached (MMIO) access controller: turns one memory-stage request into a
// single-beat AXI read or write, stalls the pipeline while the bus is busy and
// pulses a one-cycle completion (hit) to the uncache data stage.
//
// Handshake rule on every AXI channel: a transfer happens in the cycle where
// both valid and ready are high at the rising clock edge. A valid, once raised,
// is held with stable payload until its transfer; ready never depends on valid
// from this side being low.
module ysyx_2022040010_uncache_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // memory-stage request
  input  logic                req_valid,
  input  logic                req_uncache,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  // pipeline / data-stage side
  output logic                stall,
  output logic                hit,
  output logic                uncache_o,
  output logic                refresh,
  output logic [DATA_W-1:0]   axi_rdata_o,
  output logic                bus_err,
  // read address channel
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [2:0]          ar_size,
  // read data channel
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  // write address channel
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [2:0]          aw_size,
  // write data channel
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  // write response channel
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp,
  // debug view of the controller state
  output logic [2:0]          o_dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_size;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_wen;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_aw_done;
  logic                r_w_done;

  logic w_accept;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_aw_all;
  logic w_w_all;
  logic w_wr_both;

  assign w_accept  = (r_state == S_IDLE) & req_valid & req_uncache;
  assign w_aw_fire = aw_valid & aw_ready;
  assign w_w_fire  = w_valid & w_ready;
  // A channel counts as done if it finished earlier or transfers this cycle.
  assign w_aw_all  = r_aw_done | w_aw_fire;
  assign w_w_all   = r_w_done | w_w_fire;
  assign w_wr_both = w_aw_all & w_w_all;

  // Next-state selection for the single-outstanding transaction FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = req_wen ? S_WR_REQ : S_RD_ADDR;
      S_RD_ADDR: if (ar_ready) w_state_nxt = S_RD_DATA;
      S_RD_DATA: if (r_valid) w_state_nxt = S_DONE;
      S_WR_REQ:  if (w_wr_both) w_state_nxt = S_WR_RESP;
      S_WR_RESP: if (b_valid) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any bus cycle in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch the request payload in the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wen   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_size  <= req_size;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
      r_wen   <= req_wen;
    end
  end

  // Per-channel done flags for the independent AW and W handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if ((r_state != S_WR_REQ) || w_wr_both) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_aw_done <= w_aw_all;
      r_w_done  <= w_w_all;
    end
  end

  // Capture the response; error responses and stores leave zero read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if ((r_state == S_RD_DATA) && r_valid) begin
      r_err   <= r_resp[1];
      r_rdata <= r_resp[1] ? '0 : r_data;
    end else if ((r_state == S_WR_RESP) && b_valid) begin
      r_err   <= b_resp[1];
      r_rdata <= '0;
    end
  end

  assign stall = w_accept | (r_state == S_RD_ADDR) | (r_state == S_RD_DATA)
               | (r_state == S_WR_REQ) | (r_state == S_WR_RESP);

  assign ar_valid = (r_state == S_RD_ADDR);
  assign ar_addr  = r_addr;
  assign ar_size  = r_size;
  assign r_ready  = (r_state == S_RD_DATA);

  assign aw_valid = (r_state == S_WR_REQ) & ~r_aw_done;
  assign aw_addr  = r_addr;
  assign aw_size  = r_size;
  assign w_valid  = (r_state == S_WR_REQ) & ~r_w_done;
  assign w_data   = r_wdata;
  assign w_strb   = r_wstrb;
  assign b_ready  = (r_state == S_WR_RESP);

  assign hit         = (r_state == S_DONE);
  assign uncache_o   = (r_state == S_DONE);
  assign refresh     = (r_state == S_DONE) & ~r_wen;
  assign bus_err     = (r_state == S_DONE) & r_err;
  assign axi_rdata_o = r_rdata;
  assign o_dbg_state = r_state;

endmodule
